// File: rtl/error_monitor_bank.sv
// Sticky error-monitor latch bank: masked level/edge capture into active-low flags,
// per-group summaries and clears, plus a first-error index and a saturating event counter.
module error_monitor_bank #(
  parameter int NCH        = 26,
  parameter int GROUP_SIZE = 8,
  parameter int CNT_W      = 4,
  parameter int EDGE_MODE  = 0,
  localparam int NGRP      = (NCH + GROUP_SIZE - 1) / GROUP_SIZE,
  localparam int IDX_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             V1,
  input  logic [NCH-1:0]   ERR_IN,
  input  logic [NCH-1:0]   ERR_MASK,
  input  logic [NGRP-1:0]  RST_REQ,
  input  logic             RST_ALL,
  output logic [NCH-1:0]   EMN,
  output logic [NGRP-1:0]  EMRG,
  output logic             FIRST_VALID,
  output logic [IDX_W-1:0] FIRST_CH,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             OVF
);

  logic [NCH-1:0]   em_q, em_d;
  logic [NCH-1:0]   prev_q, prev_d;
  logic             first_valid_q, first_valid_d;
  logic [IDX_W-1:0] first_ch_q, first_ch_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             ovf_q, ovf_d;

  logic [NCH-1:0]   trig, new_v, clr;
  logic [IDX_W-1:0] low_idx;
  logic             any_new;
  logic [CNT_W-1:0] cnt_base;
  logic             ovf_base, fv_base;

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    clr     = '0;
    low_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      clr[i] = RST_ALL | RST_REQ[i / GROUP_SIZE];
    end
    // Edge mode qualifies each input with its previous V1 sample.
    trig    = ERR_IN & ~ERR_MASK & ((EDGE_MODE != 0) ? ~prev_q : {NCH{1'b1}});
    new_v   = trig & ~em_q;
    any_new = |new_v;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (new_v[i]) low_idx = IDX_W'(i);
    end

    cnt_base = RST_ALL ? '0 : err_cnt_q;
    ovf_base = RST_ALL ? 1'b0 : ovf_q;
    fv_base  = RST_ALL ? 1'b0 : first_valid_q;

    em_d          = em_q;
    prev_d        = prev_q;
    first_valid_d = first_valid_q;
    first_ch_d    = first_ch_q;
    err_cnt_d     = err_cnt_q;
    ovf_d         = ovf_q;

    if (V1) begin
      // A set on the same edge as a clear wins.
      em_d      = trig | (em_q & ~clr);
      prev_d    = ERR_IN;
      err_cnt_d = cnt_base;
      ovf_d     = ovf_base;
      if (any_new) begin
        if (cnt_base == {CNT_W{1'b1}}) ovf_d = 1'b1;
        else                           err_cnt_d = cnt_base + 1'b1;
      end
      if (!fv_base && any_new) begin
        first_valid_d = 1'b1;
        first_ch_d    = low_idx;
      end else if (RST_ALL) begin
        first_valid_d = 1'b0;
        first_ch_d    = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      em_q          <= '0;
      prev_q        <= '0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
      err_cnt_q     <= '0;
      ovf_q         <= 1'b0;
    end else begin
      em_q          <= em_d;
      prev_q        <= prev_d;
      first_valid_q <= first_valid_d;
      first_ch_q    <= first_ch_d;
      err_cnt_q     <= err_cnt_d;
      ovf_q         <= ovf_d;
    end
  end

  // Group summaries come straight from the flags; a partial last group only sees real channels.
  always_comb begin
    EMRG = '0;
    for (int i = 0; i < NCH; i++) begin
      EMRG[i / GROUP_SIZE] = EMRG[i / GROUP_SIZE] | em_q[i];
    end
  end

  assign EMN         = ~em_q;
  assign FIRST_VALID = first_valid_q;
  assign FIRST_CH    = first_ch_q;
  assign ERR_CNT     = err_cnt_q;
  assign OVF         = ovf_q;

endmodule

// File: tb/tb_error_monitor_bank.sv
// Scoreboard bench for error_monitor_bank: a level-mode default instance and an
// edge-mode instance with a 2-bit counter, driven from hand-derived expectations.
module tb_error_monitor_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Level-mode instance (defaults)
  logic        l_v1, l_rst_all;
  logic [25:0] l_err, l_mask, l_emn;
  logic [3:0]  l_rst_req, l_emrg, l_cnt;
  logic        l_fv, l_ovf;
  logic [4:0]  l_fch;

  // Edge-mode instance, CNT_W = 2
  logic        e_v1, e_rst_all;
  logic [25:0] e_err, e_mask, e_emn;
  logic [3:0]  e_rst_req, e_emrg;
  logic [1:0]  e_cnt;
  logic        e_fv, e_ovf;
  logic [4:0]  e_fch;

  error_monitor_bank l_dut (
    .SIM_CLK(clk), .SIM_RST(rst), .V1(l_v1), .ERR_IN(l_err), .ERR_MASK(l_mask),
    .RST_REQ(l_rst_req), .RST_ALL(l_rst_all), .EMN(l_emn), .EMRG(l_emrg),
    .FIRST_VALID(l_fv), .FIRST_CH(l_fch), .ERR_CNT(l_cnt), .OVF(l_ovf)
  );

  error_monitor_bank #(.CNT_W(2), .EDGE_MODE(1)) e_dut (
    .SIM_CLK(clk), .SIM_RST(rst), .V1(e_v1), .ERR_IN(e_err), .ERR_MASK(e_mask),
    .RST_REQ(e_rst_req), .RST_ALL(e_rst_all), .EMN(e_emn), .EMRG(e_emrg),
    .FIRST_VALID(e_fv), .FIRST_CH(e_fch), .ERR_CNT(e_cnt), .OVF(e_ovf)
  );

  typedef struct {
    bit          sel;   // 0 = level instance, 1 = edge instance
    string       tag;
    logic [25:0] emn;
    logic [3:0]  emrg;
    logic        fv;
    logic [4:0]  fch;
    logic [3:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(bit sel, string tag, logic [25:0] flags, logic [3:0] emrg,
                                   logic fv, logic [4:0] fch, logic [3:0] cnt, logic ovf);
    exp_t e;
    e.sel = sel; e.tag = tag; e.emn = ~flags; e.emrg = emrg;
    e.fv = fv; e.fch = fch; e.cnt = cnt; e.ovf = ovf;
    sb_q.push_back(e);
  endfunction

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel) begin
        check({e.tag, "/emn"},  64'(e_emn),  64'(e.emn));
        check({e.tag, "/emrg"}, 64'(e_emrg), 64'(e.emrg));
        check({e.tag, "/fv"},   64'(e_fv),   64'(e.fv));
        check({e.tag, "/fch"},  64'(e_fch),  64'(e.fch));
        check({e.tag, "/cnt"},  64'(e_cnt),  64'(e.cnt));
        check({e.tag, "/ovf"},  64'(e_ovf),  64'(e.ovf));
      end else begin
        check({e.tag, "/emn"},  64'(l_emn),  64'(e.emn));
        check({e.tag, "/emrg"}, 64'(l_emrg), 64'(e.emrg));
        check({e.tag, "/fv"},   64'(l_fv),   64'(e.fv));
        check({e.tag, "/fch"},  64'(l_fch),  64'(e.fch));
        check({e.tag, "/cnt"},  64'(l_cnt),  64'(e.cnt));
        check({e.tag, "/ovf"},  64'(l_ovf),  64'(e.ovf));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drain();
  endtask

  function automatic logic [25:0] bit26(int i);
    logic [25:0] one;
    one = 26'd1;
    return one << i;
  endfunction

  initial begin
    rst = 1'b1;
    l_v1 = 0; l_rst_all = 0; l_err = '0; l_mask = '0; l_rst_req = '0;
    e_v1 = 0; e_rst_all = 0; e_err = '0; e_mask = '0; e_rst_req = '0;
    #12;
    push_exp(0, "reset_l", '0, 4'b0000, 0, 5'd0, 4'd0, 0);
    push_exp(1, "reset_e", '0, 4'b0000, 0, 5'd0, 4'd0, 0);
    drain();
    #10 rst = 1'b0;

    // Level capture on channel 9, then input drops: flag is sticky
    l_v1 = 1; l_err = bit26(9);
    push_exp(0, "cap9", bit26(9), 4'b0010, 1, 5'd9, 4'd1, 0);
    cycle();
    l_err = '0;
    push_exp(0, "cap9_sticky", bit26(9), 4'b0010, 1, 5'd9, 4'd1, 0);
    cycle();

    // Set channel 5, then set 3 while clearing group 0
    l_err = bit26(5);
    push_exp(0, "cap5", bit26(9) | bit26(5), 4'b0011, 1, 5'd9, 4'd2, 0);
    cycle();
    l_err = bit26(3); l_rst_req = 4'b0001;
    push_exp(0, "set_wins", bit26(9) | bit26(3), 4'b0011, 1, 5'd9, 4'd3, 0);
    cycle();

    l_err = '0; l_rst_req = '0; l_rst_all = 1;
    push_exp(0, "rst_all_l", '0, 4'b0000, 0, 5'd0, 4'd0, 0);
    cycle();
    l_rst_all = 0;

    // Several channels on one edge: lowest index recorded, one count
    l_err = bit26(20) | bit26(4) | bit26(12);
    push_exp(0, "multi", bit26(20) | bit26(4) | bit26(12), 4'b0111, 1, 5'd4, 4'd1, 0);
    cycle();
    l_err = bit26(0);
    push_exp(0, "later0", bit26(20) | bit26(4) | bit26(12) | bit26(0), 4'b0111, 1, 5'd4, 4'd2, 0);
    cycle();
    l_err = '0; l_rst_req = 4'b0001;
    push_exp(0, "grp0_clr", bit26(20) | bit26(12), 4'b0110, 1, 5'd4, 4'd2, 0);
    cycle();
    l_rst_req = '0;

    // Masked input cannot set; masking a latched flag holds it
    l_err = bit26(2); l_mask = bit26(2) | bit26(12);
    push_exp(0, "mask", bit26(20) | bit26(12), 4'b0110, 1, 5'd4, 4'd2, 0);
    cycle();
    l_mask = '0;

    // V1 low: nothing moves, even with errors and RST_ALL present
    l_v1 = 0; l_err = bit26(7); l_rst_all = 1;
    for (int k = 0; k < 10; k++) begin
      push_exp(0, $sformatf("v1_low%0d", k), bit26(20) | bit26(12), 4'b0110, 1, 5'd4, 4'd2, 0);
      cycle();
    end
    l_rst_all = 0; l_err = '0;

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    push_exp(0, "async_rst_l", '0, 4'b0000, 0, 5'd0, 4'd0, 0);
    push_exp(1, "async_rst_e", '0, 4'b0000, 0, 5'd0, 4'd0, 0);
    drain();
    #2 rst = 1'b0;

    // RST_ALL together with an event in the partial last group
    l_v1 = 1; l_rst_all = 1; l_err = bit26(25);
    push_exp(0, "rst_all_evt", bit26(25), 4'b1000, 1, 5'd25, 4'd1, 0);
    cycle();
    l_rst_all = 0; l_err = '0; l_v1 = 0;

    // Edge instance: five pulses on channel 1, each followed by a group-0 clear
    e_v1 = 1;
    for (int k = 1; k <= 5; k++) begin
      logic [3:0] c;
      c = (k < 3) ? 4'(k) : 4'd3;
      e_err = bit26(1); e_rst_req = '0;
      push_exp(1, $sformatf("pulse%0d", k), bit26(1), 4'b0001, 1, 5'd1, c, k >= 4);
      cycle();
      e_err = '0; e_rst_req = 4'b0001;
      push_exp(1, $sformatf("pulse%0d_clr", k), '0, 4'b0000, 1, 5'd1, c, k >= 4);
      cycle();
    end
    e_rst_req = '0; e_rst_all = 1;
    push_exp(1, "rst_all_e", '0, 4'b0000, 0, 5'd0, 4'd0, 0);
    cycle();
    e_rst_all = 0;

    // Held-high input triggers only once in edge mode
    e_err = bit26(6);
    push_exp(1, "edge6", bit26(6), 4'b0001, 1, 5'd6, 4'd1, 0);
    cycle();
    e_rst_req = 4'b0001;
    push_exp(1, "edge6_held", '0, 4'b0000, 1, 5'd6, 4'd1, 0);
    cycle();
    e_rst_req = '0; e_err = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
